// File: rtl/thermal_guard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : thermal_guard_pkg
//  Description : Shared types and constants for the thermal_guard block.
//                Holds the per-channel state encoding, the trip counter
//                width and a small constant-evaluable max helper.
//  Revision    : 1.0  initial release
// ============================================================================
package thermal_guard_pkg;

    localparam int TRIP_W = 8;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        ARMING  = 2'd1,
        TRIPPED = 2'd2,
        COOLING = 2'd3
    } ch_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/thermal_guard_ch.sv
`default_nettype none
// ============================================================================
//  Module      : thermal_guard_ch
//  Description : One overheat channel. Debounces the raw flag, holds the
//                shutdown command while tripped and releases it after a run
//                of consecutive cool samples.
//  Build macro : THERMAL_GUARD_STICKY_EN - when defined, a tripped channel
//                only starts cooling after an operator clear_fault while the
//                channel is not overheated.
//  Ports       : clk, reset        clock / synchronous active-high reset
//                overheated        raw overheat flag for this channel
//                clear_fault       operator acknowledge (sticky build only)
//                shut_off          shutdown command (TRIPPED or COOLING)
//                trip              one-cycle strobe: this edge enters TRIPPED
//                                  from OK or ARMING
//  Revision    : 1.0  initial release
// ============================================================================
module thermal_guard_ch
    import thermal_guard_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int COOLDOWN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic overheated,
    input  logic clear_fault,
    output logic shut_off,
    output logic trip
);

    localparam int               CNT_W   = $clog2(max_int(DEBOUNCE, COOLDOWN) + 1);
    // Counter value at which the current edge is the last required sample.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ch_state_t        state;
    ch_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             release_ok;

`ifdef THERMAL_GUARD_STICKY_EN
    assign release_ok = ~overheated & clear_fault;
`else
    assign release_ok = ~overheated;
    logic unused_clear_fault;
    assign unused_clear_fault = clear_fault;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. The counter always holds the number of consecutive
    // qualifying samples already seen, so "cnt >= *_LAST" means the sample
    // on this edge completes the run.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        trip      = 1'b0;
        case (state)
            OK: begin
                if (overheated) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = TRIPPED;
                        cnt_nxt   = '0;
                        trip      = 1'b1;
                    end else begin
                        state_nxt = ARMING;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ARMING: begin
                if (!overheated) begin
                    state_nxt = OK;
                    cnt_nxt   = '0;
                end else if (cnt >= DB_LAST) begin
                    state_nxt = TRIPPED;
                    cnt_nxt   = '0;
                    trip      = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            TRIPPED: begin
                if (release_ok) begin
                    // The releasing edge already counts as the first cool sample.
                    if (COOLDOWN == 1) begin
                        state_nxt = OK;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = COOLING;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            COOLING: begin
                if (overheated) begin
                    // Re-heat during cooldown: not a new trip event.
                    state_nxt = TRIPPED;
                    cnt_nxt   = '0;
                end else if (cnt >= CD_LAST) begin
                    state_nxt = OK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = OK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode straight from the state register, no extra stage.
    always_comb begin
        shut_off = (state == TRIPPED) || (state == COOLING);
    end

endmodule
`default_nettype wire

// File: rtl/thermal_guard.sv
`default_nettype none
// ============================================================================
//  Module      : thermal_guard
//  Description : N_CH independent debounced overheat channels with a shared
//                saturating count of trip events.
//  Build macro : THERMAL_GUARD_STICKY_EN - sticky tripped state released
//                only by clear_fault (see thermal_guard_ch).
//  Ports       : clk, reset        clock / synchronous active-high reset
//                overheated[N_CH]  raw per-channel overheat flags
//                clear_fault       operator acknowledge
//                shut_off[N_CH]    per-channel shutdown command
//                keep_running      high when no channel is shut off
//                trip_count[8]     saturating trip event count since reset
//  Revision    : 1.0  initial release
// ============================================================================
module thermal_guard
    import thermal_guard_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DEBOUNCE = 3,
    parameter int COOLDOWN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   overheated,
    input  logic              clear_fault,
    output logic [N_CH-1:0]   shut_off,
    output logic              keep_running,
    output logic [TRIP_W-1:0] trip_count
);

    localparam int POP_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]  trip;
    logic [POP_W-1:0] n_trips;
    logic [TRIP_W:0]  trip_sum;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            thermal_guard_ch #(
                .DEBOUNCE (DEBOUNCE),
                .COOLDOWN (COOLDOWN)
            ) u_ch (
                .clk         (clk),
                .reset       (reset),
                .overheated  (overheated[i]),
                .clear_fault (clear_fault),
                .shut_off    (shut_off[i]),
                .trip        (trip[i])
            );
        end
    endgenerate

    // Several channels may trip on the same edge; all of them are counted.
    always_comb begin
        n_trips = '0;
        for (int i = 0; i < N_CH; i++) begin
            n_trips = n_trips + POP_W'(trip[i]);
        end
    end

    // One extra bit catches the carry out so the count can clamp at all-ones.
    assign trip_sum = {1'b0, trip_count} + (TRIP_W + 1)'(n_trips);

    always_ff @(posedge clk) begin
        if (reset) begin
            trip_count <= '0;
        end else if (trip_sum[TRIP_W]) begin
            trip_count <= '1;
        end else begin
            trip_count <= trip_sum[TRIP_W-1:0];
        end
    end

    assign keep_running = ~|shut_off;

endmodule
`default_nettype wire

// File: tb/tb_thermal_guard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thermal_guard
//  Description : Self-checking bench for thermal_guard (N_CH=4, DEBOUNCE=3,
//                COOLDOWN=8). A behavioural model based on run lengths of
//                high/low samples predicts every cycle's outputs; predictions
//                are queued when stimulus is applied and popped after the edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_thermal_guard;

    localparam int N_CH     = 4;
    localparam int DEBOUNCE = 3;
    localparam int COOLDOWN = 8;
`ifdef THERMAL_GUARD_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] overheated = '0;
    logic            clear_fault = 1'b0;
    logic [N_CH-1:0] shut_off;
    logic            keep_running;
    logic [7:0]      trip_count;

    thermal_guard #(
        .N_CH     (N_CH),
        .DEBOUNCE (DEBOUNCE),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .overheated   (overheated),
        .clear_fault  (clear_fault),
        .shut_off     (shut_off),
        .keep_running (keep_running),
        .trip_count   (trip_count)
    );

    always #5 clk = ~clk;

    // Model state: run lengths of high/low samples, latched shutdown flag,
    // and whether a sticky trip has been acknowledged.
    int  m_hi  [N_CH];
    int  m_lo  [N_CH];
    bit  m_sh  [N_CH];
    bit  m_rel [N_CH];
    int  m_tc;

    // Expected {shut_off, keep_running, trip_count}
    logic [N_CH+8:0] sb[$];
    logic [N_CH+8:0] exp_v;

    int n_chk  = 0;
    int n_pass = 0;

    // Apply one cycle of stimulus, predict the post-edge outputs, queue the
    // prediction and advance to just after the edge.
    task automatic step(input logic [N_CH-1:0] ov, input logic clr, input logic rst);
        logic [N_CH-1:0] sv;
        int              ntrip;
        overheated  = ov;
        clear_fault = clr;
        reset       = rst;
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                m_hi[i] = 0; m_lo[i] = 0; m_sh[i] = 1'b0; m_rel[i] = 1'b0;
            end
            m_tc = 0;
        end else begin
            ntrip = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (ov[i]) begin
                    m_hi[i] = m_hi[i] + 1;
                    m_lo[i] = 0;
                    if (m_sh[i]) begin
                        m_rel[i] = 1'b0;
                    end else if (m_hi[i] >= DEBOUNCE) begin
                        m_sh[i]  = 1'b1;
                        m_rel[i] = 1'b0;
                        ntrip    = ntrip + 1;
                    end
                end else begin
                    m_hi[i] = 0;
                    if (m_sh[i] && (!STICKY || m_rel[i] || clr)) begin
                        m_rel[i] = 1'b1;
                        m_lo[i]  = m_lo[i] + 1;
                        if (m_lo[i] >= COOLDOWN) begin
                            m_sh[i]  = 1'b0;
                            m_lo[i]  = 0;
                            m_rel[i] = 1'b0;
                        end
                    end
                end
            end
            m_tc = (m_tc + ntrip > 255) ? 255 : m_tc + ntrip;
        end
        for (int i = 0; i < N_CH; i++) sv[i] = m_sh[i];
        sb.push_back({sv, ~|sv, 8'(m_tc)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step('1, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        n_chk++;
        if ({shut_off, keep_running, trip_count} !== exp_v)
            $display("FAIL reset_sb0: got %h want %h", {shut_off, keep_running, trip_count}, exp_v);
        else n_pass++;
        step('0, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        n_chk++;
        if ({shut_off, keep_running, trip_count} !== exp_v)
            $display("FAIL reset_sb1: got %h want %h", {shut_off, keep_running, trip_count}, exp_v);
        else n_pass++;
        n_chk++;
        if (shut_off !== 4'h0 || keep_running !== 1'b1 || trip_count !== 8'd0)
            $display("FAIL reset_state: got so=%h kr=%b tc=%0d want so=0 kr=1 tc=0",
                     shut_off, keep_running, trip_count);
        else n_pass++;
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 5; k++) begin
            step((k < DEBOUNCE - 1) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if ({shut_off, keep_running, trip_count} !== exp_v)
                $display("FAIL glitch_sb%0d: got %h want %h", k, {shut_off, keep_running, trip_count}, exp_v);
            else n_pass++;
        end
        n_chk++;
        if (shut_off !== 4'h0 || trip_count !== 8'd0)
            $display("FAIL glitch_end: got so=%h tc=%0d want so=0 tc=0", shut_off, trip_count);
        else n_pass++;
    endtask

    task automatic test_trip_release();
        for (int k = 0; k < 3; k++) begin
            step(4'b0010, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if ({shut_off, keep_running, trip_count} !== exp_v)
                $display("FAIL trip_sb%0d: got %h want %h", k, {shut_off, keep_running, trip_count}, exp_v);
            else n_pass++;
        end
        n_chk++;
        if (shut_off !== 4'b0010 || keep_running !== 1'b0 || trip_count !== 8'd1)
            $display("FAIL trip_3rd_edge: got so=%h kr=%b tc=%0d want so=2 kr=0 tc=1",
                     shut_off, keep_running, trip_count);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            step(4'b0000, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if ({shut_off, keep_running, trip_count} !== exp_v)
                $display("FAIL cool_sb%0d: got %h want %h", k, {shut_off, keep_running, trip_count}, exp_v);
            else n_pass++;
            if (k == 7) begin
                n_chk++;
                if (shut_off[1] !== 1'b1)
                    $display("FAIL cool_7th_low: got %b want 1", shut_off[1]);
                else n_pass++;
            end
        end
        n_chk++;
        if (shut_off[1] !== 1'b0 || keep_running !== 1'b1)
            $display("FAIL cool_8th_low: got so1=%b kr=%b want so1=0 kr=1", shut_off[1], keep_running);
        else n_pass++;
    endtask

    task automatic test_cooling_reassert();
        logic [N_CH-1:0] pat [17];
        for (int k = 0; k < 17; k++) pat[k] = (k < 3 || k == 8) ? 4'b0010 : 4'b0000;
        for (int k = 0; k < 17; k++) begin
            step(pat[k], 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if ({shut_off, keep_running, trip_count} !== exp_v)
                $display("FAIL reassert_sb%0d: got %h want %h", k, {shut_off, keep_running, trip_count}, exp_v);
            else n_pass++;
            if (k == 8 || k == 15) begin
                n_chk++;
                if (shut_off[1] !== 1'b1 || trip_count !== 8'd2)
                    $display("FAIL reassert_hold%0d: got so1=%b tc=%0d want so1=1 tc=2",
                             k, shut_off[1], trip_count);
                else n_pass++;
            end
        end
        n_chk++;
        if (shut_off[1] !== 1'b0)
            $display("FAIL reassert_release: got %b want 0", shut_off[1]);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 65; r++) begin
            for (int k = 0; k < 11; k++) begin
                step((k < 3) ? 4'hF : 4'h0, 1'b0, 1'b0);
                exp_v = sb.pop_front();
                n_chk++;
                if ({shut_off, keep_running, trip_count} !== exp_v)
                    $display("FAIL sat_sb r%0d k%0d: got %h want %h", r, k,
                             {shut_off, keep_running, trip_count}, exp_v);
                else n_pass++;
                if (r == 0 && k == 2) begin
                    n_chk++;
                    if (trip_count !== 8'd6 || shut_off !== 4'hF)
                        $display("FAIL sat_plus4: got so=%h tc=%0d want so=f tc=6", shut_off, trip_count);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (trip_count !== 8'd255)
            $display("FAIL sat_hold: got %0d want 255", trip_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_cooling();
        for (int k = 0; k < 7; k++) begin
            step((k < 3) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if ({shut_off, keep_running, trip_count} !== exp_v)
                $display("FAIL rstcool_sb%0d: got %h want %h", k, {shut_off, keep_running, trip_count}, exp_v);
            else n_pass++;
        end
        step(4'b0100, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        n_chk++;
        if ({shut_off, keep_running, trip_count} !== exp_v)
            $display("FAIL rstcool_sb_rst: got %h want %h", {shut_off, keep_running, trip_count}, exp_v);
        else n_pass++;
        n_chk++;
        if (shut_off !== 4'h0 || keep_running !== 1'b1 || trip_count !== 8'd0)
            $display("FAIL rstcool_state: got so=%h kr=%b tc=%0d want so=0 kr=1 tc=0",
                     shut_off, keep_running, trip_count);
        else n_pass++;
    endtask

`ifdef THERMAL_GUARD_STICKY_EN
    task automatic test_sticky();
        // 3 high, 20 low, clear while hot, 1 low, clear pulse, 7 low
        for (int k = 0; k < 33; k++) begin
            step((k < 3 || k == 23) ? 4'b0001 : 4'b0000, (k == 23 || k == 25), 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if ({shut_off, keep_running, trip_count} !== exp_v)
                $display("FAIL sticky_sb%0d: got %h want %h", k, {shut_off, keep_running, trip_count}, exp_v);
            else n_pass++;
            if (k == 22 || k == 24 || k == 31) begin
                n_chk++;
                if (shut_off[0] !== 1'b1)
                    $display("FAIL sticky_hold%0d: got %b want 1", k, shut_off[0]);
                else n_pass++;
            end
        end
        n_chk++;
        if (shut_off[0] !== 1'b0)
            $display("FAIL sticky_release: got %b want 0", shut_off[0]);
        else n_pass++;
    endtask
`else
    task automatic test_clear_ignored();
        for (int k = 0; k < 13; k++) begin
            step((k < 5) ? 4'b1000 : 4'b0000, 1'b1, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if ({shut_off, keep_running, trip_count} !== exp_v)
                $display("FAIL clear_sb%0d: got %h want %h", k, {shut_off, keep_running, trip_count}, exp_v);
            else n_pass++;
            if (k == 4 || k == 11) begin
                n_chk++;
                if (shut_off[3] !== 1'b1)
                    $display("FAIL clear_hold%0d: got %b want 1", k, shut_off[3]);
                else n_pass++;
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        for (int k = 0; k < 400; k++) begin
            step(N_CH'($urandom_range(0, 15) | (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
            exp_v = sb.pop_front();
            n_chk++;
            if ({shut_off, keep_running, trip_count} !== exp_v)
                $display("FAIL random_sb%0d: got %h want %h", k, {shut_off, keep_running, trip_count}, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_glitch();
        test_trip_release();
        test_cooling_reassert();
        test_saturation();
        test_reset_mid_cooling();
`ifdef THERMAL_GUARD_STICKY_EN
        test_sticky();
`else
        test_clear_ignored();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/thermal_guard.md
THERMAL_GUARD -- requirements
Module: thermal_guard

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent overheat channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE, default 3, consecutive high samples required to trip a channel (>=1).
REQ-003 SHALL have parameter COOLDOWN, default 8, consecutive low samples required to release a tripped channel (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port overheated  input  N_CH  per-channel raw overheat flag, sampled each edge.
REQ-007 SHALL have port clear_fault  input  1  operator acknowledge (used only when sticky mode is compiled in).
REQ-008 SHALL have port shut_off  output  N_CH  registered per-channel shutdown command.
REQ-009 SHALL have port keep_running  output  1  high when no bit of shut_off is set (combinational from registered shut_off only).
REQ-010 SHALL have port trip_count  output  8  saturating count of channel trip events since reset.

Function
REQ-011 Each channel SHALL run an independent FSM with states OK, ARMING, TRIPPED, COOLING and its own counter.
REQ-012 OK: overheated=1 -> ARMING, counter=1; if DEBOUNCE=1 -> TRIPPED directly at that edge.
REQ-013 ARMING: overheated=0 -> OK, counter=0; overheated=1 -> counter+1; TRIPPED on the edge sampling the DEBOUNCE-th consecutive high.
REQ-014 shut_off[i] SHALL be 1 exactly in TRIPPED and COOLING; rise latency is DEBOUNCE edges from first high sample, no extra pipeline stage.
REQ-015 TRIPPED: overheated=0 -> COOLING, counter=1 (non-sticky build); overheated=1 -> stay.
REQ-016 COOLING: overheated=1 -> TRIPPED, counter=0, no new trip event counted; on the edge sampling the COOLDOWN-th consecutive low -> OK, shut_off[i] drops at that edge.
REQ-017 A trip event is any transition into TRIPPED from OK or ARMING; trip_count SHALL add the number of channels tripping on the same edge and saturate at 255.
REQ-018 Counters SHALL be sized clog2(max(DEBOUNCE,COOLDOWN)+1) bits and never wrap.
REQ-019 Glitches shorter than DEBOUNCE samples SHALL never assert shut_off.

Reset
REQ-020 reset=1 at an edge SHALL force all channels to OK, counters=0, shut_off=0, trip_count=0, regardless of current state or inputs; keep_running=1 the following cycle.
REQ-021 Reset SHALL take priority over every other event, including mid-ARMING and mid-COOLING.

Configuration
REQ-022 Macro THERMAL_GUARD_STICKY_EN defined: TRIPPED exits only on an edge with clear_fault=1 and overheated[i]=0, then enters COOLING with counter=1; clear_fault while overheated[i]=1 is ignored.
REQ-023 Macro undefined: TRIPPED -> COOLING automatically per REQ-015; clear_fault SHALL have no effect on any state.

Structure
REQ-024 Package thermal_guard_pkg SHALL hold the channel state enum (OK, ARMING, TRIPPED, COOLING) and constant TRIP_W=8.
REQ-025 Per-channel FSM SHALL be sub-module thermal_guard_ch, instantiated N_CH times via generate; top holds trip popcount and saturating counter.

Verification
REQ-026 DEBOUNCE=3: overheated[0] high 2 cycles then low -> shut_off stays 0, trip_count=0.
REQ-027 overheated[1] high 3 cycles -> shut_off[1]=1 on 3rd edge, keep_running=0, trip_count=1; low 8 cycles -> shut_off[1]=0 on 8th low edge.
REQ-028 COOLING at count 5, overheated[1] re-asserts -> shut_off stays 1, trip_count unchanged; full 8-cycle cooldown restarts.
REQ-029 All 4 channels high simultaneously 3 cycles -> trip_count +4 on one edge; repeated to exceed 255 -> holds 255.
REQ-030 Reset asserted while channel 2 in COOLING -> next edge shut_off=0, trip_count=0, keep_running=1.
REQ-031 STICKY_EN build: trip ch0, overheated low 20 cycles -> shut_off[0] still 1; clear_fault pulse -> 8 cycles later shut_off[0]=0.
